// File: rtl/posit_chk_pkg.sv
// Shared definitions for the posit adder result checker: default posit
// geometry, statistics counter width and the session FSM encoding.
package posit_chk_pkg;

  localparam int POSIT_N  = 32;
  localparam int POSIT_ES = 2;
  localparam int CNT_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/posit_chk_fifo.sv
// Synchronous FIFO holding expected adder outputs until the matching result
// arrives. A pop and a push in the same cycle are both serviced even when
// full, because the pop frees the slot the push needs. An entry pushed into
// an empty FIFO is not visible to a pop in that same cycle.
module posit_chk_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Payload storage.
  // NOTE: the array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers; a session clear empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/posit_add_checker.sv
// Receive-side checker for the posit adder stream. Expected sums are queued
// at launch and matched in order against each adder done pulse; every
// compare reports its error magnitude and feeds session statistics.
module posit_add_checker
  import posit_chk_pkg::*;
#(
  parameter int             N     = POSIT_N,
  parameter int             ES    = POSIT_ES,
  parameter int             DEPTH = 8,
  parameter logic [N-1:0]   TOL   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             exp_valid,
  input  logic [N-1:0]     exp_result,
  input  logic             exp_inf,
  input  logic             exp_zero,
  input  logic             dut_done,
  input  logic [N-1:0]     dut_result,
  input  logic             dut_inf,
  input  logic             dut_zero,
  output logic             chk_valid,
  output logic [N-1:0]     chk_diff,
  output logic             chk_mismatch,
  output logic [CNT_W-1:0] chk_index,
  output logic [CNT_W-1:0] n_checked,
  output logic [CNT_W-1:0] n_errors,
  output logic [N-1:0]     max_diff,
  output logic             overflow,
  output logic             underflow,
  output logic             busy,
  output logic             finished
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Elaboration-time guards on the parameter set.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two of at least 2");
  end
  if (ES < 0 || ES >= N) begin : g_bad_es
    $error("ES must lie in [0, N)");
  end

  chk_state_e   state;
  chk_state_e   state_nxt;
  logic         start_q;
  logic         start_rise;
  logic         session_clear;
  logic         push_en;
  logic         pop_req;
  logic         do_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [N+1:0] fifo_rdata;
  logic [N-1:0] head_result;
  logic         head_inf;
  logic         head_zero;
  logic [N-1:0] diff;
  logic         mismatch;

  assign start_rise    = start && !start_q;
  assign session_clear = start_rise && (state == ST_IDLE || state == ST_DONE);
  assign push_en       = exp_valid && (state == ST_RUN);
  assign pop_req       = dut_done && (state == ST_RUN || state == ST_DRAIN);
  assign do_pop        = pop_req && !fifo_empty;

  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign finished = (state == ST_DONE);

  posit_chk_fifo #(
    .W     (N + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (session_clear),
    .push    (push_en),
    .pop     (do_pop),
    .wdata   ({exp_inf, exp_zero, exp_result}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_inf    = fifo_rdata[N+1];
  assign head_zero   = fifo_rdata[N];
  assign head_result = fifo_rdata[N-1:0];

  // Absolute difference of raw patterns and the mismatch decision.
  always_comb begin
    diff = (head_result > dut_result) ? (head_result - dut_result)
                                      : (dut_result - head_result);
    mismatch = (diff > TOL) || (head_inf != dut_inf) || (head_zero != dut_zero);
  end

  // FSM state register and start edge history.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  // Session sequencing: run while start is held, drain once it drops.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_rise) state_nxt = ST_RUN;
      ST_RUN:   if (!start) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !dut_done) state_nxt = ST_DONE;
      ST_DONE:  if (start_rise) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-sample report registers, saturating statistics and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_valid    <= 1'b0;
      chk_diff     <= '0;
      chk_mismatch <= 1'b0;
      chk_index    <= '0;
      n_checked    <= '0;
      n_errors     <= '0;
      max_diff     <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (session_clear) begin
      chk_valid    <= 1'b0;
      chk_diff     <= '0;
      chk_mismatch <= 1'b0;
      chk_index    <= '0;
      n_checked    <= '0;
      n_errors     <= '0;
      max_diff     <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      chk_valid <= do_pop;
      if (do_pop) begin
        chk_diff     <= diff;
        chk_mismatch <= mismatch;
        chk_index    <= n_checked;
        if (n_checked != '1) n_checked <= n_checked + CNT_ONE;
        if (mismatch && n_errors != '1) n_errors <= n_errors + CNT_ONE;
        if (diff > max_diff) max_diff <= diff;
      end
      if (push_en && fifo_full && !do_pop) overflow <= 1'b1;
      if (pop_req && fifo_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_posit_add_checker.sv
// Directed bench for posit_add_checker: stimulus pushes hand-computed compare
// results into a scoreboard queue, and a monitor pops and compares them
// whenever the checker reports a sample.
`timescale 1ns/1ps
module tb_posit_add_checker;

  localparam int N     = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [N-1:0]  diff;
    logic          mis;
    logic [31:0]   idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          exp_valid;
  logic [N-1:0]  exp_result;
  logic          exp_inf;
  logic          exp_zero;
  logic          dut_done;
  logic [N-1:0]  dut_result;
  logic          dut_inf;
  logic          dut_zero;
  logic          chk_valid;
  logic [N-1:0]  chk_diff;
  logic          chk_mismatch;
  logic [31:0]   chk_index;
  logic [31:0]   n_checked;
  logic [31:0]   n_errors;
  logic [N-1:0]  max_diff;
  logic          overflow;
  logic          underflow;
  logic          busy;
  logic          finished;

  always #5 clk = ~clk;

  posit_add_checker #(
    .N     (N),
    .ES    (2),
    .DEPTH (DEPTH),
    .TOL   (32'd0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .exp_valid    (exp_valid),
    .exp_result   (exp_result),
    .exp_inf      (exp_inf),
    .exp_zero     (exp_zero),
    .dut_done     (dut_done),
    .dut_result   (dut_result),
    .dut_inf      (dut_inf),
    .dut_zero     (dut_zero),
    .chk_valid    (chk_valid),
    .chk_diff     (chk_diff),
    .chk_mismatch (chk_mismatch),
    .chk_index    (chk_index),
    .n_checked    (n_checked),
    .n_errors     (n_errors),
    .max_diff     (max_diff),
    .overflow     (overflow),
    .underflow    (underflow),
    .busy         (busy),
    .finished     (finished)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb_q [$];
  exp_t mon_e;

  // Stream tables: expected side, adder side, hand-computed compare result.
  logic [N-1:0] s_exp   [20];
  logic         s_einf  [20];
  logic         s_ezero [20];
  logic [N-1:0] s_res   [20];
  logic         s_rinf  [20];
  logic         s_rzero [20];
  logic [N-1:0] s_xdiff [20];
  logic         s_xmis  [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_chk_valid"},    64'(chk_valid),    64'd0);
    check({tag, "_chk_diff"},     64'(chk_diff),     64'd0);
    check({tag, "_chk_mismatch"}, 64'(chk_mismatch), 64'd0);
    check({tag, "_chk_index"},    64'(chk_index),    64'd0);
    check({tag, "_n_checked"},    64'(n_checked),    64'd0);
    check({tag, "_n_errors"},     64'(n_errors),     64'd0);
    check({tag, "_max_diff"},     64'(max_diff),     64'd0);
    check({tag, "_overflow"},     64'(overflow),     64'd0);
    check({tag, "_underflow"},    64'(underflow),    64'd0);
    check({tag, "_busy"},         64'(busy),         64'd0);
    check({tag, "_finished"},     64'(finished),     64'd0);
  endtask

  task automatic wait_finished(input string tag);
    for (int i = 0; i < 32 && !finished; i++) tick();
    check({tag, "_finished"}, 64'(finished), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  // Adder model with a fixed 4-cycle latency: sample t is launched at cycle t
  // and its done pulse arrives at cycle t+4.
  task automatic run_stream(input int n);
    for (int t = 0; t < n + 4; t++) begin
      exp_valid = (t < n);
      if (t < n) begin
        exp_result = s_exp[t];
        exp_inf    = s_einf[t];
        exp_zero   = s_ezero[t];
      end
      dut_done = (t >= 4);
      if (t >= 4) begin
        dut_result = s_res[t-4];
        dut_inf    = s_rinf[t-4];
        dut_zero   = s_rzero[t-4];
        sb_q.push_back('{diff: s_xdiff[t-4], mis: s_xmis[t-4], idx: 32'(t - 4)});
      end
      tick();
    end
    exp_valid = 1'b0;
    dut_done  = 1'b0;
  endtask

  task automatic push_only(input logic [N-1:0] v);
    exp_valid  = 1'b1;
    exp_result = v;
    exp_inf    = 1'b0;
    exp_zero   = 1'b0;
    tick();
    exp_valid  = 1'b0;
  endtask

  // Monitor: every reported sample must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && chk_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_chk_valid", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("chk_diff[%0d]", mon_e.idx),     64'(chk_diff),     64'(mon_e.diff));
        check($sformatf("chk_mismatch[%0d]", mon_e.idx), 64'(chk_mismatch), 64'(mon_e.mis));
        check($sformatf("chk_index[%0d]", mon_e.idx),    64'(chk_index),    64'(mon_e.idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    exp_valid  = 1'b0;
    exp_result = '0;
    exp_inf    = 1'b0;
    exp_zero   = 1'b0;
    dut_done   = 1'b0;
    dut_result = '0;
    dut_inf    = 1'b0;
    dut_zero   = 1'b0;

    // Reset values.
    repeat (2) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Session 1: clean stream of 20 samples, including matching flag cases.
    for (int i = 0; i < 20; i++) begin
      s_exp[i]   = 32'h3000_0000 + 32'(i) * 32'h0101_0101;
      s_einf[i]  = 1'b0;
      s_ezero[i] = 1'b0;
      s_xdiff[i] = '0;
      s_xmis[i]  = 1'b0;
    end
    s_exp[7]  = 32'h0000_0000; s_ezero[7] = 1'b1;
    s_exp[11] = 32'h8000_0000; s_einf[11] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_res[i]   = s_exp[i];
      s_rinf[i]  = s_einf[i];
      s_rzero[i] = s_ezero[i];
    end
    start = 1'b1;
    tick();
    check("s1_busy", 64'(busy), 64'd1);
    run_stream(20);
    start = 1'b0;
    wait_finished("s1");
    check("s1_n_checked", 64'(n_checked), 64'd20);
    check("s1_n_errors",  64'(n_errors),  64'd0);
    check("s1_max_diff",  64'(max_diff),  64'd0);
    check("s1_overflow",  64'(overflow),  64'd0);
    check("s1_underflow", 64'(underflow), 64'd0);

    // Session 2: value error on sample 5, flag-only error on sample 2.
    for (int i = 0; i < 8; i++) begin
      s_exp[i]   = 32'h4800_0000 + 32'(i);
      s_einf[i]  = 1'b0;
      s_ezero[i] = 1'b0;
      s_res[i]   = s_exp[i];
      s_rinf[i]  = 1'b0;
      s_rzero[i] = 1'b0;
      s_xdiff[i] = '0;
      s_xmis[i]  = 1'b0;
    end
    s_exp[5] = 32'h4000_0000; s_res[5] = 32'h4000_0003;
    s_xdiff[5] = 32'd3; s_xmis[5] = 1'b1;
    s_exp[2] = 32'h8000_0000; s_einf[2] = 1'b1;
    s_res[2] = 32'h8000_0000; s_rinf[2] = 1'b0;
    s_xdiff[2] = 32'd0; s_xmis[2] = 1'b1;
    start = 1'b1;
    tick();
    check("s2_cleared_n_checked", 64'(n_checked), 64'd0);
    check("s2_finished_low", 64'(finished), 64'd0);
    run_stream(8);
    start = 1'b0;
    wait_finished("s2");
    check("s2_n_checked", 64'(n_checked), 64'd8);
    check("s2_n_errors",  64'(n_errors),  64'd2);
    check("s2_max_diff",  64'(max_diff),  64'd3);

    // Session 3: fill the FIFO, push+pop at full, overflow, drain, underflow.
    start = 1'b1;
    tick();
    check("s3_cleared_max_diff", 64'(max_diff), 64'd0);
    for (int k = 0; k < 8; k++) push_only(32'h1000_0000 + 32'(k));
    exp_valid  = 1'b1;
    exp_result = 32'h1000_0008;
    dut_done   = 1'b1;
    dut_result = 32'h1000_0000;
    dut_inf    = 1'b0;
    dut_zero   = 1'b0;
    sb_q.push_back('{diff: '0, mis: 1'b0, idx: 32'd0});
    tick();
    exp_valid = 1'b0;
    dut_done  = 1'b0;
    check("s3_full_pushpop_overflow", 64'(overflow), 64'd0);
    push_only(32'h1000_0099);
    check("s3_overflow", 64'(overflow), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      dut_done   = 1'b1;
      dut_result = 32'h1000_0000 + 32'(k);
      sb_q.push_back('{diff: '0, mis: 1'b0, idx: 32'(k)});
      tick();
    end
    dut_done = 1'b0;
    tick();
    check("s3_underflow_before", 64'(underflow), 64'd0);
    check("s3_n_checked", 64'(n_checked), 64'd9);
    dut_done   = 1'b1;
    dut_result = 32'h1000_0099;
    tick();
    dut_done = 1'b0;
    check("s3_underflow", 64'(underflow), 64'd1);
    check("s3_empty_no_chk_valid", 64'(chk_valid), 64'd0);
    check("s3_n_checked_after_underflow", 64'(n_checked), 64'd9);
    check("s3_n_errors", 64'(n_errors), 64'd0);
    start = 1'b0;
    wait_finished("s3");

    // Session 4: reset mid-run with 3 entries still queued.
    start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) push_only(32'h0000_0020 + 32'(k));
    dut_done   = 1'b1;
    dut_result = 32'h0000_0025;
    sb_q.push_back('{diff: 32'd5, mis: 1'b1, idx: 32'd0});
    tick();
    dut_done = 1'b0;
    tick();
    check("s4_pre_n_errors", 64'(n_errors), 64'd1);
    reset_n = 1'b0;
    start   = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("post_reset_busy", 64'(busy), 64'd0);
    start = 1'b1;
    tick();
    check("post_reset_run_busy", 64'(busy), 64'd1);
    dut_done = 1'b1;
    tick();
    dut_done = 1'b0;
    check("post_reset_fifo_empty_underflow", 64'(underflow), 64'd1);
    check("post_reset_no_chk_valid", 64'(chk_valid), 64'd0);
    check("post_reset_n_checked", 64'(n_checked), 64'd0);
    tick();
    start = 1'b0;
    wait_finished("s4");

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
